// File: rtl/dm_sba_axi_bridge.sv
// Debug-module system-bus access to AXI4 master bridge.
// Single-beat accesses, at most one outstanding, with a one-cycle completion pulse.
module dm_sba_axi_bridge #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0]  AXI_ID     = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // Debug-module side
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  output logic                      r_valid_o,
  output logic [DATA_WIDTH-1:0]     r_rdata_o,
  output logic                      r_err_o,
  output logic                      busy_o,
  // AXI4 write address
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ID_WIDTH-1:0]       awid,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awlock,
  output logic [3:0]                awcache,
  output logic [2:0]                awprot,
  // AXI4 write data
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  // AXI4 write response
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  input  logic [ID_WIDTH-1:0]       bid,
  // AXI4 read address
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ID_WIDTH-1:0]       arid,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  // AXI4 read data
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic [ID_WIDTH-1:0]       rid,
  input  logic                      rlast
);

  localparam logic [2:0] AxiSize = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  typedef enum logic [2:0] {StIdle, StWr, StWresp, StRd, StRdata} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic                    we_q;
  logic                    awvalid_q, wvalid_q, arvalid_q;
  logic                    r_valid_q, r_err_q;
  logic [DATA_WIDTH-1:0]   r_rdata_q;

  logic aw_done, w_done, cpl_err;
  logic unused_in;

  // A channel counts as done once its valid has already dropped or is handshaking now.
  assign aw_done = ~awvalid_q | awready;
  assign w_done  = ~wvalid_q | wready;
  assign cpl_err = we_q ? bresp[1] : rresp[1];

  assign unused_in = ^{bid, rid, rlast, bresp[0], rresp[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      r_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            we_q    <= we_i;
            if (we_i) begin
              state_q   <= StWr;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= StRd;
              arvalid_q <= 1'b1;
            end
          end
        end
        StWr: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) state_q <= StWresp;
        end
        StWresp: begin
          if (bvalid) begin
            state_q   <= StIdle;
            r_valid_q <= 1'b1;
            r_err_q   <= cpl_err;
          end
        end
        StRd: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (rvalid) begin
            state_q   <= StIdle;
            r_valid_q <= 1'b1;
            r_err_q   <= cpl_err;
            r_rdata_q <= rdata;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o     = req_i & (state_q == StIdle);
  assign busy_o    = (state_q != StIdle);
  assign r_valid_o = r_valid_q;
  assign r_err_o   = r_err_q;
  assign r_rdata_o = r_rdata_q;

  assign awvalid = awvalid_q;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = AxiSize;
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wvalid = wvalid_q;
  assign wdata  = wdata_q;
  assign wstrb  = be_q;
  assign wlast  = 1'b1;

  assign bready = (state_q == StWresp);

  assign arvalid = arvalid_q;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = AxiSize;
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign rready = (state_q == StRdata);

endmodule

// File: tb/tb_dm_sba_axi_bridge.sv
// Directed bench for dm_sba_axi_bridge: scripted AXI slave timing per scenario,
// hand-computed expectations checked a cycle at a time.
module tb_dm_sba_axi_bridge;

  logic        clk, rst_n;
  logic        req_i, gnt_o, we_i, r_valid_o, r_err_o, busy_o;
  logic [31:0] addr_i, wdata_i, r_rdata_o;
  logic [3:0]  be_i;
  logic        awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  awid, awcache, wstrb, bid, arid, arcache, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic        arvalid, arready, arlock, rvalid, rready, rlast;

  int tests = 0;
  int fails = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, pulses = 0;

  dm_sba_axi_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
    .be_i(be_i), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
    .busy_o(busy_o),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and pulse counters observed from the slave side.
  always @(posedge clk) begin
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready)   w_hs++;
    if (arvalid && arready) ar_hs++;
  end
  always @(negedge clk) if (r_valid_o) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = 4'h5;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rid = 4'h9; rlast = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    tests++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin fails++;
      $display("FAIL rst_valids: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready}); end
    tests++; if ({r_valid_o, r_err_o, busy_o} !== 3'b0) begin fails++;
      $display("FAIL rst_status: got %b want 000", {r_valid_o, r_err_o, busy_o}); end
    tests++; if (r_rdata_o !== 32'h0 || awaddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0)
      begin fails++; $display("FAIL rst_data: got %h/%h/%h/%h want zeros",
        r_rdata_o, awaddr, wdata, wstrb); end
    tests++; if ({awlen, awsize, awburst, awlock, awcache, awprot, awid} !== {8'd0, 3'd2, 2'b01,
        1'b0, 4'd0, 3'd0, 4'd0}) begin fails++;
      $display("FAIL aw_attr: got len %h size %h burst %b", awlen, awsize, awburst); end
    tests++; if ({arlen, arsize, arburst, arlock, arcache, arprot, arid, wlast} !== {8'd0, 3'd2,
        2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 1'b1}) begin fails++;
      $display("FAIL ar_attr: got len %h size %h burst %b wlast %b", arlen, arsize, arburst, wlast);
      end
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_basic();
    int p0, a0, w0;
    p0 = pulses; a0 = aw_hs; w0 = w_hs;
    req_i = 1; we_i = 1; addr_i = 32'h0000_1000; wdata_i = 32'hDEAD_BEEF; be_i = 4'hF;
    awready = 1; wready = 1;
    #1;
    tests++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL wr_gnt: got %b want 1", gnt_o); end
    tick(); req_i = 0; addr_i = '0; wdata_i = '0; be_i = '0; #1;
    tests++; if ({awvalid, wvalid, busy_o} !== 3'b111) begin fails++;
      $display("FAIL wr_valids: got %b want 111", {awvalid, wvalid, busy_o}); end
    tests++; if (awaddr !== 32'h1000 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF || wlast !== 1)
      begin fails++; $display("FAIL wr_payload: got %h %h %h %b want 00001000 deadbeef f 1",
        awaddr, wdata, wstrb, wlast); end
    tick(); awready = 0; wready = 0;
    tests++; if ({awvalid, wvalid, bready} !== 3'b001) begin fails++;
      $display("FAIL wr_wresp: got %b want 001", {awvalid, wvalid, bready}); end
    tick();
    tests++; if (r_valid_o !== 1'b0) begin fails++;
      $display("FAIL wr_early_pulse: got %b want 0", r_valid_o); end
    tick(); bvalid = 1; bresp = 2'b00;
    tick(); bvalid = 0;
    tests++; if ({r_valid_o, r_err_o, busy_o, bready} !== 4'b1000) begin fails++;
      $display("FAIL wr_cpl: got %b want 1000", {r_valid_o, r_err_o, busy_o, bready}); end
    tick();
    tests++; if (r_valid_o !== 1'b0) begin fails++;
      $display("FAIL wr_pulse_len: got %b want 0", r_valid_o); end
    tests++; if (pulses - p0 != 1 || aw_hs - a0 != 1 || w_hs - w0 != 1) begin fails++;
      $display("FAIL wr_counts: got pulses %0d aw %0d w %0d want 1 1 1",
        pulses - p0, aw_hs - a0, w_hs - w0); end
  endtask

  task automatic test_read_delay();
    int p0;
    p0 = pulses;
    req_i = 1; we_i = 0; addr_i = 32'h8000_0004; arready = 0;
    #1;
    tests++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL rd_gnt: got %b want 1", gnt_o); end
    tick(); req_i = 0; addr_i = '0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004 || rready !== 1'b0) begin fails++;
        $display("FAIL rd_ar_hold%0d: got %b %h %b want 1 80000004 0", i, arvalid, araddr, rready);
        end
      if (i == 3) arready = 1;
      tick();
    end
    arready = 0;
    tests++; if ({arvalid, rready} !== 2'b01 || r_rdata_o !== 32'h0) begin fails++;
      $display("FAIL rd_rdata_state: got %b %h want 01 00000000", {arvalid, rready}, r_rdata_o); end
    rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00; rlast = 1;
    tick(); rvalid = 0; rdata = 32'hFFFF_FFFF;
    tests++; if (r_valid_o !== 1'b1 || r_rdata_o !== 32'h1234_5678 || r_err_o !== 1'b0) begin
      fails++; $display("FAIL rd_cpl: got %b %h %b want 1 12345678 0",
        r_valid_o, r_rdata_o, r_err_o); end
    tick();
    tests++; if (r_valid_o !== 1'b0 || r_rdata_o !== 32'h1234_5678 || pulses - p0 != 1) begin
      fails++; $display("FAIL rd_hold: got %b %h pulses %0d want 0 12345678 1",
        r_valid_o, r_rdata_o, pulses - p0); end
  endtask

  task automatic test_write_split();
    int p0, a0, w0;
    p0 = pulses; a0 = aw_hs; w0 = w_hs;
    req_i = 1; we_i = 1; addr_i = 32'h44; wdata_i = 32'hCAFE_F00D; be_i = 4'h3;
    awready = 1; wready = 0;
    #1;
    tests++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL sp_gnt: got %b want 1", gnt_o); end
    tick(); req_i = 0; wdata_i = '0;
    tests++; if ({awvalid, wvalid} !== 2'b11) begin fails++;
      $display("FAIL sp_first: got %b want 11", {awvalid, wvalid}); end
    tick(); awready = 0;
    for (int i = 2; i <= 6; i++) begin
      tests++; if ({awvalid, wvalid} !== 2'b01 || wdata !== 32'hCAFE_F00D || wstrb !== 4'h3)
        begin fails++; $display("FAIL sp_w_hold%0d: got %b %h %h want 01 cafef00d 3",
          i, {awvalid, wvalid}, wdata, wstrb); end
      if (i == 6) wready = 1;
      tick();
    end
    wready = 0;
    tests++; if ({wvalid, bready} !== 2'b01) begin fails++;
      $display("FAIL sp_wresp: got %b want 01", {wvalid, bready}); end
    bvalid = 1; bresp = 2'b00;
    tick(); bvalid = 0;
    tests++; if (r_valid_o !== 1'b1 || r_err_o !== 1'b0) begin fails++;
      $display("FAIL sp_cpl: got %b %b want 1 0", r_valid_o, r_err_o); end
    tick();
    tests++; if (pulses - p0 != 1 || aw_hs - a0 != 1 || w_hs - w0 != 1) begin fails++;
      $display("FAIL sp_counts: got pulses %0d aw %0d w %0d want 1 1 1",
        pulses - p0, aw_hs - a0, w_hs - w0); end
  endtask

  task automatic test_read_err();
    logic [1:0]  resp_tab [2] = '{2'b10, 2'b00};
    logic        err_tab  [2] = '{1'b1, 1'b0};
    logic [31:0] data_tab [2] = '{32'hA5A5_0001, 32'hA5A5_0002};
    for (int j = 0; j < 2; j++) begin
      req_i = 1; we_i = 0; addr_i = 32'h100 + 32'(j * 4);
      arready = 1; rvalid = 1; rresp = resp_tab[j]; rdata = data_tab[j]; rlast = 0;
      #1;
      tests++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL re_gnt%0d: got %b want 1", j, gnt_o);
        end
      tick(); req_i = 0;
      tests++; if ({arvalid, rready} !== 2'b10) begin fails++;
        $display("FAIL re_rd%0d: got %b want 10", j, {arvalid, rready}); end
      tick(); arready = 0;
      tick(); rvalid = 0;
      tests++; if (r_valid_o !== 1'b1 || r_err_o !== err_tab[j] || r_rdata_o !== data_tab[j]) begin
        fails++; $display("FAIL re_cpl%0d: got %b %b %h want 1 %b %h",
          j, r_valid_o, r_err_o, r_rdata_o, err_tab[j], data_tab[j]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int p0, a0;
    logic exp_gnt, exp_ar, exp_rv, exp_busy;
    p0 = pulses; a0 = ar_hs;
    we_i = 0; addr_i = 32'h200; arready = 1; rvalid = 1; rresp = 2'b00; rlast = 1;
    for (int k = 0; k < 10; k++) begin
      req_i = (k <= 6);
      rdata = 32'hC0DE_0000 + 32'(k);
      #1;
      exp_gnt  = (k % 3 == 0) && (k <= 6);
      exp_ar   = (k % 3 == 1);
      exp_rv   = (k % 3 == 0) && (k > 0);
      exp_busy = (k % 3 != 0);
      tests++; if ({gnt_o, arvalid, r_valid_o, busy_o} !== {exp_gnt, exp_ar, exp_rv, exp_busy})
        begin fails++; $display("FAIL b2b_cyc%0d: got %b want %b", k,
          {gnt_o, arvalid, r_valid_o, busy_o}, {exp_gnt, exp_ar, exp_rv, exp_busy}); end
      if (exp_rv) begin
        tests++; if (r_rdata_o !== 32'hC0DE_0000 + 32'(k - 1)) begin fails++;
          $display("FAIL b2b_data%0d: got %h want %h", k, r_rdata_o, 32'hC0DE_0000 + 32'(k - 1));
          end
      end
      tick();
    end
    req_i = 0; arready = 0; rvalid = 0;
    tests++; if (pulses - p0 != 3 || ar_hs - a0 != 3) begin fails++;
      $display("FAIL b2b_counts: got pulses %0d ar %0d want 3 3", pulses - p0, ar_hs - a0); end
  endtask

  task automatic test_reset_mid();
    int p0, a0;
    req_i = 1; we_i = 1; addr_i = 32'h3000; wdata_i = 32'h1111_2222; be_i = 4'hF;
    awready = 1; wready = 1;
    tick(); req_i = 0;
    tick(); awready = 0; wready = 0;
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL rm_in_wresp: got %b want 1", bready);
      end
    p0 = pulses;
    rst_n = 0; bvalid = 1; bresp = 2'b00;
    #1;
    tests++; if ({busy_o, bready, awvalid, wvalid, arvalid, rready, r_valid_o} !== 7'b0) begin
      fails++; $display("FAIL rm_outputs: got %b want 0000000",
        {busy_o, bready, awvalid, wvalid, arvalid, rready, r_valid_o}); end
    tests++; if (r_rdata_o !== 32'h0 || awaddr !== 32'h0 || wdata !== 32'h0) begin fails++;
      $display("FAIL rm_data: got %h %h %h want zeros", r_rdata_o, awaddr, wdata); end
    tick(); tick();
    rst_n = 1; bvalid = 0;
    tick();
    tests++; if (r_valid_o !== 1'b0 || busy_o !== 1'b0 || pulses != p0) begin fails++;
      $display("FAIL rm_no_pulse: got %b %b pulses %0d want 0 0 0", r_valid_o, busy_o, pulses - p0);
      end
    p0 = pulses; a0 = aw_hs;
    req_i = 1; we_i = 1; addr_i = 32'h2000; wdata_i = 32'h5555_AAAA; be_i = 4'hC;
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b11;
    #1;
    tests++; if (gnt_o !== 1'b1) begin fails++; $display("FAIL rm_regrant: got %b want 1", gnt_o);
      end
    tick(); req_i = 0;
    tests++; if (awaddr !== 32'h2000 || wstrb !== 4'hC || awvalid !== 1'b1) begin fails++;
      $display("FAIL rm_aw: got %h %h %b want 00002000 c 1", awaddr, wstrb, awvalid); end
    tick(); awready = 0; wready = 0;
    tick(); bvalid = 0;
    tests++; if (r_valid_o !== 1'b1 || r_err_o !== 1'b1) begin fails++;
      $display("FAIL rm_cpl: got %b %b want 1 1", r_valid_o, r_err_o); end
    tick();
    tests++; if (pulses - p0 != 1 || aw_hs - a0 != 1) begin fails++;
      $display("FAIL rm_counts: got pulses %0d aw %0d want 1 1", pulses - p0, aw_hs - a0); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_delay();
    test_write_split();
    test_read_err();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
